// File: rtl/mips_md_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: md_op opcodes and FSM states,
// plus small opcode classification helpers.
package mips_md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_e;

  // Operations that occupy the iterative datapath.
  function automatic logic is_iter_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sign_adj.sv
// Conditional two's-complement negate. With neg = signed & msb it yields a magnitude;
// with neg = result-sign it applies the final sign correction.
module md_sign_adj #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (-a) : a;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers. Shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with sign correction on completion.
module mult_div_unit
  import mips_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_op_e    op;
  md_state_e state;

  logic [CNT_W-1:0] count;
  // Shared accumulator: multiply keeps {partial product, multiplier}; divide keeps
  // {partial remainder, dividend shifting into quotient}.
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rs_orig;
  logic             is_div, neg_res, neg_rem, dz;

  logic             op_signed, op_div, op_iter;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op        = md_op_e'(md_op);
  assign op_signed = is_signed_op(op);
  assign op_div    = is_div_op(op);
  assign op_iter   = is_iter_op(op);
  assign busy      = (state != IDLE);

  md_sign_adj #(.W(WIDTH)) u_rs_abs (.a(rs), .neg(op_signed & rs[WIDTH-1]), .y(rs_mag));
  md_sign_adj #(.W(WIDTH)) u_rt_abs (.a(rt), .neg(op_signed & rt[WIDTH-1]), .y(rt_mag));

  md_sign_adj #(.W(2*WIDTH)) u_prod_fix (.a({acc_hi, acc_lo}), .neg(neg_res), .y(prod_fix));
  md_sign_adj #(.W(WIDTH))   u_quo_fix  (.a(acc_lo), .neg(neg_res), .y(quo_fix));
  md_sign_adj #(.W(WIDTH))   u_rem_fix  (.a(acc_hi), .neg(neg_rem), .y(rem_fix));

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    nxt_hi    = acc_hi;
    nxt_lo    = acc_lo;
    mul_sum   = {1'b0, acc_hi} + ({(WIDTH+1){acc_lo[0]}} & {1'b0, b_mag});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_mag});
    // When div_ge holds the difference is below the divisor, so WIDTH bits suffice.
    div_rem   = div_shift[WIDTH-1:0] - b_mag;
    if (is_div) begin
      nxt_hi = div_ge ? div_rem : div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      {nxt_hi, nxt_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      b_mag       <= '0;
      rs_orig     <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dz          <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_iter) begin
              count   <= '0;
              acc_hi  <= '0;
              acc_lo  <= op_div ? rs_mag : rt_mag;
              b_mag   <= op_div ? rt_mag : rs_mag;
              rs_orig <= rs;
              is_div  <= op_div;
              neg_res <= op_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
              neg_rem <= op_signed & rs[WIDTH-1];
              dz      <= op_div & (rt == '0);
              state   <= RUN;
            end else if (op == MD_MTHI) begin
              hi <= rs;
            end else if (op == MD_MTLO) begin
              lo <= rs;
            end
          end
        end
        RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          count  <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH-1)) state <= DONE;
        end
        DONE: begin
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (dz) begin
            // Divide by zero reports the untouched dividend rather than the iteration result.
            hi          <= rs_orig;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-level reference model built from plain
// 64-bit arithmetic, a per-cycle compare process, directed corner cases and random traffic.
module tb_mult_div_unit;
  import mips_md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   md_op;
  logic [W-1:0] rs, rt;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int  n_checks = 0;
  int  n_fail   = 0;
  logic chk_en  = 1'b0;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from the arithmetic definition of each operation.
  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } res_t;

  function automatic res_t model_op(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t        r;
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    r = '0;
    case (op)
      MD_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {r.hi, r.lo} = sp;
      end
      MD_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {r.hi, r.lo} = up;
      end
      MD_DIV: begin
        if (b == 0) begin
          r.hi = a; r.lo = '1; r.dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.hi = '0; r.lo = 32'h8000_0000;
        end else begin
          sa = a; sb = b;
          r.lo = sa / sb;
          r.hi = sa % sb;
        end
      end
      MD_DIVU: begin
        if (b == 0) begin
          r.hi = a; r.lo = '1; r.dz = 1'b1;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  // Timing model: an accepted mult/div keeps the unit busy for WIDTH+1 edges, then commits.
  int           m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_done = 1'b0, m_dz = 1'b0;
  res_t         p_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= p_res.hi;
          m_lo   <= p_res.lo;
          m_done <= 1'b1;
          m_dz   <= p_res.dz;
        end
      end else if (start) begin
        case (md_op_e'(md_op))
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            p_res  <= model_op(md_op_e'(md_op), rs, rt);
            m_left <= W + 1;
          end
          MD_MTHI: m_hi <= rs;
          MD_MTLO: m_lo <= rs;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_left != 0));
      check("done", 64'(done), 64'(m_done));
      check("div_by_zero", 64'(div_by_zero), 64'(m_dz));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  // Pulses start for one cycle; returns at the first falling edge after the start edge,
  // with the operand inputs already scrambled.
  task automatic issue(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    md_op = op; rs = a; rt = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rs = $urandom; rt = $urandom; md_op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(output logic [W-1:0] h, output logic [W-1:0] l,
                           output logic d, output int bcyc);
    logic got;
    got = 1'b0; bcyc = 0; h = '0; l = '0; d = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy) bcyc++;
      if (done) begin
        got = 1'b1; h = hi; l = lo; d = div_by_zero;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 64'(got), 64'(1));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] h, l;
    logic         d;
    int           bc;
    logic         seen;
    md_op_e       rop;

    rst_n = 1'b0; start = 1'b0; md_op = '0; rs = '0; rt = '0;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));

    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(h, l, d, bc);
    check("mult_hi", 64'(h), 64'hFFFF_FFFF);
    check("mult_lo", 64'(l), 64'hFFFF_FFEB);
    check("mult_busy_cycles", 64'(bc), 64'd33);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(h, l, d, bc);
    check("multu_hi", 64'(h), 64'hFFFF_FFFE);
    check("multu_lo", 64'(l), 64'h0000_0001);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(h, l, d, bc);
    check("div_lo", 64'(l), 64'hFFFF_FFFD);
    check("div_hi", 64'(h), 64'hFFFF_FFFF);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(h, l, d, bc);
    check("div_ovf_lo", 64'(l), 64'h8000_0000);
    check("div_ovf_hi", 64'(h), 64'h0);
    check("div_ovf_flag", 64'(d), 64'(0));

    issue(MD_DIVU, 32'd100, 32'd0);
    wait_done(h, l, d, bc);
    check("divz_lo", 64'(l), 64'hFFFF_FFFF);
    check("divz_hi", 64'(h), 64'h64);
    check("divz_flag", 64'(d), 64'(1));
    check("divz_busy_cycles", 64'(bc), 64'd33);

    // Second request while busy must be dropped.
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    repeat (3) @(negedge clk);
    md_op = MD_DIVU; rs = 32'd9; rt = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(h, l, d, bc);
    check("ignored_hi", 64'(h), 64'hFFFF_FFFF);
    check("ignored_lo", 64'(l), 64'hFFFF_FFFA);

    issue(MD_MTLO, 32'h1234_5678, 32'd0);
    check("mtlo_lo", 64'(lo), 64'h1234_5678);
    check("mtlo_busy", 64'(busy), 64'(0));
    check("mtlo_done", 64'(done), 64'(0));
    issue(MD_MTHI, 32'hCAFE_F00D, 32'd0);
    check("mthi_hi", 64'(hi), 64'hCAFE_F00D);

    // Reset in the middle of a divide.
    issue(MD_DIV, 32'd1000, 32'd7);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'(0));

    issue(MD_MULT, 32'd6, 32'd7);
    wait_done(h, l, d, bc);
    check("post_reset_lo", 64'(l), 64'd42);
    check("post_reset_hi", 64'(h), 64'd0);

    // Random traffic, with occasional requests while busy.
    for (int n = 0; n < 60; n++) begin
      rop = md_op_e'(3'($urandom_range(0, 7)));
      issue(rop, pick(), pick());
      if (is_iter_op(rop) && ($urandom_range(0, 2) == 0)) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        md_op = 3'($urandom_range(0, 7)); rs = $urandom; rt = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (!busy) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("idle_reached", 64'(seen), 64'(1));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the single-cycle MIPS datapath.
- Sits beside the ALU, downstream of the ALU control decode. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multi-cycle: asserts busy so the pipeline/PC logic stalls until HI/LO results are valid.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- md_op  input  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved.
- rs  input  WIDTH  multiplicand/dividend; data for MTHI/MTLO.
- rt  input  WIDTH  multiplier/divisor.
- busy  output  1  high while a mult/div is in flight.
- done  output  1  one-cycle pulse when new HI/LO from mult/div are visible.
- div_by_zero  output  1  pulses with done when a DIV/DIVU had rt=0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi, lo, counters and internal accumulators = 0; busy=0, done=0, div_by_zero=0.
- Reset asserted mid-operation aborts it immediately. No partial result is written.
- FSM states:
  - IDLE: start=1 with MULT/MULTU/DIV/DIVU → latch operands, count=0, go RUN.
  - RUN: one iteration per cycle. When count=WIDTH-1 → DONE.
  - DONE: apply sign correction, register hi/lo, set done → IDLE.
- busy = (state != IDLE).
- Latency: start sampled at edge E0. RUN occupies WIDTH cycles and DONE one cycle. New hi/lo and the done pulse are visible in the cycle after edge E0+WIDTH+1, which is IDLE again.
- MTHI/MTLO: start in IDLE writes hi (or lo) = rs at the next edge. busy and done stay low.
- start with NONE or 111 is ignored. start while busy=1 is ignored; no queueing.
- Multiply:
  - Shift-add on magnitudes, 2*WIDTH-bit product.
  - Signed (MULT): magnitude = two's-complement abs; product negated if operand signs differ.
  - {hi,lo} = product.
- Divide:
  - Restoring divide on magnitudes, one quotient bit per cycle.
  - Signed (DIV): quotient negated if signs differ; remainder takes the sign of the dividend.
  - lo = quotient, hi = remainder.
- Divide by zero (rt=0): lo = all ones, hi = rs (original dividend, unmodified); div_by_zero=1 with done. Timing is the same as a normal divide.
- Signed overflow (most-negative / -1): lo = 0x80000000 (WIDTH-generic: MSB only), hi = 0. No flag.
- Operand inputs may change after the start edge; only the latched copies are used.
- hi/lo hold their values whenever they are not being written.

Decomposition:
- Shared package mips_md_pkg:
  - md_op encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - FSM state encoding (IDLE, RUN, DONE).
- One natural sub-module: md_sign_adj, combinational. It provides conditional two's-complement abs/negate, used both for input magnitudes and for result correction.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 → after WIDTH+2 cycles: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses 1 cycle; busy high exactly 33 cycles.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rs=100, rt=0 → lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 coincident with done.
- MULT started, then start with DIVU at cycle 5 → second request ignored; final result is the MULT product. Next, MTLO rs=0x12345678 in IDLE → lo=0x12345678 next cycle, busy and done stay 0.
- DIV in flight, rst_n=0 at cycle 10 → immediately busy=0, hi=lo=0, no done pulse. After release, a new MULT 6×7 gives lo=42, hi=0.
